// File: rtl/fpu_seq_pkg.sv
// Shared definitions for the FPU operand sequencer: state encoding,
// result flag layout and rounding-mode codes.
package fpu_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_BEGIN,
        S_WAIT,
        S_WRITE,
        S_CLEAR,
        S_DONE
    } seq_state_t;

    localparam int FLAG_TO  = 2;
    localparam int FLAG_OVF = 1;
    localparam int FLAG_UNF = 0;

    localparam logic [1:0] RM_NEAREST = 2'd0;
    localparam logic [1:0] RM_ZERO    = 2'd1;
    localparam logic [1:0] RM_POS     = 2'd2;
    localparam logic [1:0] RM_NEG     = 2'd3;

    function automatic logic [2:0] make_flags(input logic timeout,
                                              input logic ovf,
                                              input logic unf);
        logic [2:0] f;
        f           = '0;
        f[FLAG_TO]  = timeout;
        f[FLAG_OVF] = ovf;
        f[FLAG_UNF] = unf;
        return f;
    endfunction

endpackage

// File: rtl/fpu_seq_timeout.sv
// Cycle counter for the FPU wait phase; a zero limit disables expiry.
// expired is asserted on the last allowed cycle while counting is enabled.
module fpu_seq_timeout #(
    parameter int TO_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            count_en,
    input  logic [TO_W-1:0] limit,
    output logic            expired
);

    logic [TO_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (count_en && !expired) begin
            count <= count + TO_W'(1);
        end
    end

    assign expired = count_en && (limit != '0) && (count == limit - TO_W'(1));

endmodule

// File: rtl/fpu_vector_sequencer.sv
// Streams operand pairs from a synchronous vector RAM through an FPU unit
// (beg/ready/rst handshake) and writes each result word plus flags out.
module fpu_vector_sequencer
    import fpu_seq_pkg::*;
#(
    parameter int W      = 32,
    parameter int ADDR_W = 10,
    parameter int TO_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   num_vectors,
    input  logic [1:0]        round_mode_cfg,
    input  logic              sweep_en,
    input  logic [TO_W-1:0]   timeout_limit,
    output logic [ADDR_W-1:0] op_addr,
    input  logic [W-1:0]      op_a_data,
    input  logic [W-1:0]      op_b_data,
    output logic              dut_beg,
    output logic              dut_rst_fsm,
    output logic [W-1:0]      dut_x,
    output logic [W-1:0]      dut_y,
    output logic [1:0]        dut_round_mode,
    input  logic              dut_ready,
    input  logic [W-1:0]      dut_result,
    input  logic              dut_ovf,
    input  logic              dut_unf,
    output logic              res_we,
    output logic [ADDR_W+1:0] res_addr,
    output logic [W-1:0]      res_data,
    output logic [2:0]        res_flags,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W+2:0] vec_count,
    output logic [ADDR_W+2:0] timeout_count
);

    localparam int IDX_W = ADDR_W + 1;
    localparam int CNT_W = ADDR_W + 3;

    seq_state_t        state;
    logic [IDX_W-1:0]  vec_idx;
    logic [IDX_W-1:0]  vec_next;
    logic [IDX_W-1:0]  nvec_q;
    logic [1:0]        mode;
    logic              sweep_q;
    logic              fresh;
    logic [TO_W-1:0]   limit_q;
    logic              to_expired;

    // One extra index bit so a full-memory batch compares before wrapping.
    assign vec_next = vec_idx + IDX_W'(1);

    fpu_seq_timeout #(
        .TO_W(TO_W)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clear    (state == S_BEGIN),
        .count_en (state == S_WAIT),
        .limit    (limit_q),
        .expired  (to_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            vec_idx        <= '0;
            nvec_q         <= '0;
            mode           <= RM_NEAREST;
            sweep_q        <= 1'b0;
            fresh          <= 1'b0;
            limit_q        <= '0;
            op_addr        <= '0;
            dut_beg        <= 1'b0;
            dut_rst_fsm    <= 1'b0;
            dut_x          <= '0;
            dut_y          <= '0;
            dut_round_mode <= RM_NEAREST;
            res_we         <= 1'b0;
            res_addr       <= '0;
            res_data       <= '0;
            res_flags      <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            vec_count      <= '0;
            timeout_count  <= '0;
        end else begin
            res_we  <= 1'b0;
            done    <= 1'b0;
            dut_beg <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        nvec_q        <= num_vectors;
                        sweep_q       <= sweep_en;
                        limit_q       <= timeout_limit;
                        mode          <= sweep_en ? RM_NEAREST : round_mode_cfg;
                        vec_idx       <= '0;
                        op_addr       <= '0;
                        vec_count     <= '0;
                        timeout_count <= '0;
                        if (num_vectors == '0) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    fresh <= 1'b1;
                    state <= S_LOAD;
                end
                // Sweep passes re-enter here with fresh=0 and keep the held operands.
                S_LOAD: begin
                    if (fresh) begin
                        dut_x <= op_a_data;
                        dut_y <= op_b_data;
                    end
                    fresh          <= 1'b0;
                    dut_round_mode <= mode;
                    dut_beg        <= 1'b1;
                    state          <= S_BEGIN;
                end
                S_BEGIN: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (dut_ready || to_expired) begin
                        res_we    <= 1'b1;
                        res_addr  <= sweep_q ? {vec_idx[ADDR_W-1:0], mode}
                                             : {2'b00, vec_idx[ADDR_W-1:0]};
                        vec_count <= vec_count + CNT_W'(1);
                        state     <= S_WRITE;
                    end
                    if (dut_ready) begin
                        res_data  <= dut_result;
                        res_flags <= make_flags(1'b0, dut_ovf, dut_unf);
                    end else if (to_expired) begin
                        res_data      <= '0;
                        res_flags     <= make_flags(1'b1, 1'b0, 1'b0);
                        timeout_count <= timeout_count + CNT_W'(1);
                    end
                end
                S_WRITE: begin
                    dut_rst_fsm <= 1'b1;
                    state       <= S_CLEAR;
                end
                S_CLEAR: begin
                    if (!dut_ready) begin
                        dut_rst_fsm <= 1'b0;
                        if (sweep_q && (mode != RM_NEG)) begin
                            mode  <= mode + 2'd1;
                            state <= S_LOAD;
                        end else if (vec_next == nvec_q) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            vec_idx <= vec_next;
                            op_addr <= vec_next[ADDR_W-1:0];
                            mode    <= sweep_q ? RM_NEAREST : mode;
                            state   <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_vector_sequencer.sv
// Scoreboard bench for fpu_vector_sequencer: a small FPU model returns A^B
// after a programmable latency; expected writes are queued and checked by a monitor.
module tb_fpu_vector_sequencer;
    import fpu_seq_pkg::*;

    localparam int W      = 32;
    localparam int ADDR_W = 4;
    localparam int TO_W   = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W:0]   num_vectors = '0;
    logic [1:0]        round_mode_cfg = '0;
    logic              sweep_en = 1'b0;
    logic [TO_W-1:0]   timeout_limit = '0;
    logic [ADDR_W-1:0] op_addr;
    logic [W-1:0]      op_a_data;
    logic [W-1:0]      op_b_data;
    logic              dut_beg;
    logic              dut_rst_fsm;
    logic [W-1:0]      dut_x;
    logic [W-1:0]      dut_y;
    logic [1:0]        dut_round_mode;
    logic              dut_ready;
    logic [W-1:0]      dut_result;
    logic              dut_ovf;
    logic              dut_unf;
    logic              res_we;
    logic [ADDR_W+1:0] res_addr;
    logic [W-1:0]      res_data;
    logic [2:0]        res_flags;
    logic              busy;
    logic              done;
    logic [ADDR_W+2:0] vec_count;
    logic [ADDR_W+2:0] timeout_count;

    typedef struct packed {
        logic [ADDR_W+1:0] addr;
        logic [W-1:0]      data;
        logic [2:0]        flags;
        logic [1:0]        rm;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int beg_cyc = 0;
    int beg_count = 0;
    int done_cycles = 0;
    int write_count = 0;
    int gap_expect = 0;
    bit busy_seen = 1'b0;

    logic [W-1:0] mem_a [0:2**ADDR_W-1];
    logic [W-1:0] mem_b [0:2**ADDR_W-1];

    int           fpu_latency = 6;
    bit           fpu_never = 1'b0;
    bit           fpu_ovf = 1'b0;
    int           fpu_cnt = 0;
    bit           fpu_pending = 1'b0;
    logic [W-1:0] fpu_res = '0;

    fpu_vector_sequencer #(
        .W      (W),
        .ADDR_W (ADDR_W),
        .TO_W   (TO_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .num_vectors    (num_vectors),
        .round_mode_cfg (round_mode_cfg),
        .sweep_en       (sweep_en),
        .timeout_limit  (timeout_limit),
        .op_addr        (op_addr),
        .op_a_data      (op_a_data),
        .op_b_data      (op_b_data),
        .dut_beg        (dut_beg),
        .dut_rst_fsm    (dut_rst_fsm),
        .dut_x          (dut_x),
        .dut_y          (dut_y),
        .dut_round_mode (dut_round_mode),
        .dut_ready      (dut_ready),
        .dut_result     (dut_result),
        .dut_ovf        (dut_ovf),
        .dut_unf        (dut_unf),
        .res_we         (res_we),
        .res_addr       (res_addr),
        .res_data       (res_data),
        .res_flags      (res_flags),
        .busy           (busy),
        .done           (done),
        .vec_count      (vec_count),
        .timeout_count  (timeout_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        op_a_data <= mem_a[op_addr];
        op_b_data <= mem_b[op_addr];
    end

    // Ready rises in the cycle fpu_latency cycles after the beg cycle and holds until rst_FSM.
    always @(posedge clk) begin
        if (rst || dut_rst_fsm) begin
            dut_ready   <= 1'b0;
            fpu_pending <= 1'b0;
            fpu_cnt     <= 0;
        end else if (dut_beg) begin
            fpu_pending <= 1'b1;
            fpu_cnt     <= 1;
            fpu_res     <= dut_x ^ dut_y;
            dut_ready   <= !fpu_never && (fpu_latency == 1);
        end else if (fpu_pending && !dut_ready) begin
            fpu_cnt <= fpu_cnt + 1;
            if (!fpu_never && (fpu_cnt + 1 == fpu_latency)) dut_ready <= 1'b1;
        end
    end

    assign dut_result = dut_ready ? fpu_res : '0;
    assign dut_ovf    = dut_ready & fpu_ovf;
    assign dut_unf    = 1'b0;

    task automatic check_value(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input int addr, input logic [W-1:0] data,
                            input logic [2:0] flags, input logic [1:0] rm);
        exp_t e;
        e.addr  = (ADDR_W+2)'(addr);
        e.data  = data;
        e.flags = flags;
        e.rm    = rm;
        exp_q.push_back(e);
    endtask

    task automatic apply_stimulus(input int n, input bit sweep, input logic [1:0] rm, input int limit);
        num_vectors    = (ADDR_W+1)'(n);
        sweep_en       = sweep;
        round_mode_cfg = rm;
        timeout_limit  = TO_W'(limit);
        done_cycles    = 0;
        write_count    = 0;
        beg_count      = 0;
        busy_seen      = 1'b0;
        start          = 1'b1;
        @(negedge clk);
        start          = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check_value("done_within_budget", 64'(seen), 64'd1);
    endtask

    task automatic wait_begs(input int n, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (beg_count >= n) seen = 1'b1;
        end
        check_value("beg_within_budget", 64'(seen), 64'd1);
    endtask

    // Monitor: every result strobe is matched against the head of the scoreboard.
    always @(negedge clk) begin
        if (dut_beg) begin
            beg_cyc = cyc;
            beg_count++;
        end
        if (done) done_cycles++;
        if (busy) busy_seen = 1'b1;
        if (res_we) begin
            write_count++;
            check_value("write_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check_value("res_addr", 64'(res_addr), 64'(mon_e.addr));
                check_value("res_data", 64'(res_data), 64'(mon_e.data));
                check_value("res_flags", 64'(res_flags), 64'(mon_e.flags));
                check_value("round_mode", 64'(dut_round_mode), 64'(mon_e.rm));
            end
            if (gap_expect != 0) check_value("timeout_wait_cycles", 64'(cyc - beg_cyc - 1), 64'(gap_expect));
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 2**ADDR_W; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        mem_a[0] = 32'h3F80_0000; mem_b[0] = 32'h4040_0000;
        mem_a[1] = 32'h4000_0000; mem_b[1] = 32'h3F00_0000;
        mem_a[2] = 32'hC049_0FDB; mem_b[2] = 32'h0000_FFFF;

        $display("[TB] reset");
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_value("rst_busy", 64'(busy), 64'd0);
        check_value("rst_done", 64'(done), 64'd0);
        check_value("rst_res_we", 64'(res_we), 64'd0);
        check_value("rst_beg", 64'(dut_beg), 64'd0);
        check_value("rst_rst_fsm", 64'(dut_rst_fsm), 64'd0);
        check_value("rst_round_mode", 64'(dut_round_mode), 64'd0);
        check_value("rst_vec_count", 64'(vec_count), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] basic batch");
        fpu_latency = 6; fpu_never = 1'b0; fpu_ovf = 1'b0;
        push_exp(0, 32'h7FC0_0000, 3'b000, 2'd2);
        push_exp(1, 32'h7F00_0000, 3'b000, 2'd2);
        push_exp(2, 32'hC049_F024, 3'b000, 2'd2);
        apply_stimulus(3, 1'b0, 2'd2, 0);
        wait_done(400);
        @(negedge clk);
        check_value("basic_done_cycles", 64'(done_cycles), 64'd1);
        check_value("basic_vec_count", 64'(vec_count), 64'd3);
        check_value("basic_writes", 64'(write_count), 64'd3);
        check_value("basic_timeouts", 64'(timeout_count), 64'd0);
        check_value("basic_busy_after", 64'(busy), 64'd0);

        $display("[TB] sweep");
        fpu_latency = 3;
        for (int v = 0; v < 2; v++)
            for (int m = 0; m < 4; m++)
                push_exp(v * 4 + m, (v == 0) ? 32'h7FC0_0000 : 32'h7F00_0000, 3'b000, 2'(m));
        apply_stimulus(2, 1'b1, 2'd2, 0);
        wait_done(600);
        @(negedge clk);
        check_value("sweep_vec_count", 64'(vec_count), 64'd8);
        check_value("sweep_writes", 64'(write_count), 64'd8);

        $display("[TB] timeout");
        fpu_never = 1'b1;
        gap_expect = 20;
        push_exp(0, 32'h0, 3'b100, 2'd1);
        push_exp(1, 32'h0, 3'b100, 2'd1);
        apply_stimulus(2, 1'b0, 2'd1, 20);
        wait_done(400);
        gap_expect = 0;
        @(negedge clk);
        check_value("to_timeout_count", 64'(timeout_count), 64'd2);
        check_value("to_vec_count", 64'(vec_count), 64'd2);

        $display("[TB] ready/timeout tie");
        fpu_never = 1'b0; fpu_latency = 20; fpu_ovf = 1'b1;
        push_exp(0, 32'h7FC0_0000, 3'b010, 2'd1);
        apply_stimulus(1, 1'b0, 2'd1, 20);
        wait_done(200);
        @(negedge clk);
        check_value("tie_timeout_count", 64'(timeout_count), 64'd0);
        check_value("tie_vec_count", 64'(vec_count), 64'd1);
        fpu_ovf = 1'b0;

        $display("[TB] zero vectors");
        apply_stimulus(0, 1'b0, 2'd0, 0);
        check_value("zero_done_next_cycle", 64'(done), 64'd1);
        @(negedge clk);
        check_value("zero_done_pulse", 64'(done), 64'd0);
        check_value("zero_busy_seen", 64'(busy_seen), 64'd0);
        check_value("zero_writes", 64'(write_count), 64'd0);

        $display("[TB] start while busy");
        fpu_latency = 6;
        push_exp(0, 32'h7FC0_0000, 3'b000, 2'd0);
        push_exp(1, 32'h7F00_0000, 3'b000, 2'd0);
        push_exp(2, 32'hC049_F024, 3'b000, 2'd0);
        apply_stimulus(3, 1'b0, 2'd0, 0);
        repeat (10) @(negedge clk);
        num_vectors = 5'd1; sweep_en = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(400);
        @(negedge clk);
        check_value("ignored_vec_count", 64'(vec_count), 64'd3);
        check_value("ignored_writes", 64'(write_count), 64'd3);

        $display("[TB] mid-batch reset");
        fpu_latency = 30;
        push_exp(0, 32'h7FC0_0000, 3'b000, 2'd3);
        apply_stimulus(3, 1'b0, 2'd3, 0);
        wait_begs(2, 200);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_value("mid_rst_busy", 64'(busy), 64'd0);
        check_value("mid_rst_res_we", 64'(res_we), 64'd0);
        check_value("mid_rst_round_mode", 64'(dut_round_mode), 64'd0);
        check_value("mid_rst_vec_count", 64'(vec_count), 64'd0);
        check_value("mid_rst_dut_x", 64'(dut_x), 64'd0);
        check_value("mid_rst_op_addr", 64'(op_addr), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check_value("mid_rst_writes", 64'(write_count), 64'd1);
        fpu_latency = 4;
        push_exp(0, 32'h7FC0_0000, 3'b000, 2'd0);
        push_exp(1, 32'h7F00_0000, 3'b000, 2'd0);
        apply_stimulus(2, 1'b0, 2'd0, 0);
        wait_done(300);
        @(negedge clk);
        check_value("restart_vec_count", 64'(vec_count), 64'd2);
        check_value("restart_writes", 64'(write_count), 64'd2);

        check_value("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
